mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage controller for the 8-bit pipelined core. It sits between the EX/MEM pipeline register and the single-port data memory, and turns the EX/MEM control fields into memory accesses. It handles loads, stores, CALL pushes, RET pops and the multi-cycle interrupt entry sequence. It owns the stack pointer and the output port, and raises `stall` and `pc_redirect` back toward the front of the pipeline.

## Interface
Parameters:
- `SP_RESET`, default 8'hFF: stack pointer value after reset.
- `INT_VEC_ADDR`, default 8'h01: memory address holding the ISR entry address.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `pc_plus1`  in  8  return address for CALL.
- `ALU_res`  in  8  load/store effective address.
- `FW_value`  in  8  store data and output-port data.
- `MemWrite`  in  1  store request.
- `MemToReg`  in  2  writeback select; 2'b01 means load.
- `IO_Write`  in  1  output-port write.
- `IP`  in  8  interrupted PC, saved on interrupt entry.
- `flags`  in  4  CCR, saved on interrupt entry.
- `isCall`  in  1  CALL in this slot.
- `isNotRet`  in  1  active-low RET marker.
- `int_signal`  in  1  interrupt entry marker.
- `mem_addr`  out  8  data memory address.
- `mem_wdata`  out  8  data memory write data.
- `mem_we`  out  1  data memory write enable.
- `mem_re`  out  1  data memory read enable.
- `mem_rdata`  in  8  synchronous read data, valid the cycle after `mem_re`.
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- `pc_redirect`  out  1  one-cycle PC load.
- `pc_target`  out  8  PC load value.
- `sp`  out  8  current stack pointer.
- `io_out`  out  8  registered output port.

## Operation
- States: IDLE, INT_FLAGS, INT_VEC, VEC_WAIT, RET_WAIT.
- Decode happens in IDLE only. Priority is `int_signal` > `isCall` > RET (`!isNotRet`) > `MemWrite` > load.
- An EX/MEM slot carrying `int_signal` is a bubble; its other fields are ignored.
- Store, in IDLE: `mem_we`=1, `mem_addr`=`ALU_res`, `mem_wdata`=`FW_value`. No stall.
- Load, in IDLE: `mem_re`=1, `mem_addr`=`ALU_res`. The writeback path captures `mem_rdata` next cycle. No stall.
- CALL, in IDLE: write `pc_plus1` to M[`sp`], then `sp`<=`sp`-1. No stall. The PC redirect for CALL is done in EX, not here.
- RET, in IDLE:
  - `mem_re`=1, `mem_addr`=`sp`+1, `sp`<=`sp`+1, `stall`=1, go to RET_WAIT.
  - In RET_WAIT: `pc_redirect`=1, `pc_target`=`mem_rdata`, go to IDLE.
- Interrupt, in IDLE:
  - Write `IP` to M[`sp`], `sp`-=1, `stall`=1, go to INT_FLAGS.
  - INT_FLAGS: write {4'b0,`flags`} to M[`sp`], `sp`-=1, `stall`=1, go to INT_VEC.
  - INT_VEC: `mem_re`=1, `mem_addr`=`INT_VEC_ADDR`, `stall`=1, go to VEC_WAIT.
  - VEC_WAIT: `pc_redirect`=1, `pc_target`=`mem_rdata`, go to IDLE.
- `IO_Write` in IDLE: `io_out`<=`FW_value`. This is independent of the memory-op priority.
- `sp` arithmetic is modulo 256: 8'h00-1 gives 8'hFF, and 8'hFF+1 gives 8'h00. There is no fault.
- When no access is performed, `mem_we`, `mem_re` and `mem_wdata` are 0, and `mem_addr` is 0.

## Timing
- Reset (`rst`=0 at a clock edge):
  - state = IDLE, `sp` = `SP_RESET`, `io_out` = 0.
  - All combinational outputs are 0 while in IDLE with zero inputs.
  - Reset mid-sequence (any state) aborts the sequence; no further writes are issued.
- Decode outputs (`mem_*`, `stall`) are combinational from state and inputs. `sp`, `io_out` and state are registered.
- Store, load and CALL take 1 cycle.
- RET: `stall` for 1 cycle, `pc_redirect` on cycle 2.
- Interrupt: `stall` for 3 cycles, `pc_redirect` on cycle 4.
- While `stall`=1, upstream holds EX/MEM, so inputs are stable. `stall` is 0 in RET_WAIT and VEC_WAIT so the slot drains.
- `pc_redirect` lasts exactly one cycle and is never asserted together with `stall`.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum;
  - the `MemToReg` encodings (2'b01 = load);
  - defaults for `SP_RESET` and `INT_VEC_ADDR`.
- Sub-module `stack_ptr` holds the `sp` register with `inc`/`dec` strobes and synchronous reset to `SP_RESET`. `mem_stage_ctrl` instantiates it.

## Test plan
- Reset with `sp`=8'h20, mid INT_FLAGS -> next cycle state IDLE, `sp`=8'hFF, `io_out`=0, no `mem_we`.
- Store `ALU_res`=8'h40, `FW_value`=8'hA5 -> `mem_we`=1 to 8'h40 with 8'hA5, `stall`=0.
- CALL with `pc_plus1`=8'h12, `sp`=8'hFF -> M[8'hFF]=8'h12, `sp`=8'hFE.
- RET with `sp`=8'hFE and M[8'hFF]=8'h12:
  - cycle 1: `stall`=1, read of 8'hFF;
  - cycle 2: `pc_redirect`=1, `pc_target`=8'h12, `sp`=8'hFF.
- Interrupt with `IP`=8'h33, `flags`=4'b1010, M[8'h01]=8'h80, `sp`=8'hFF:
  - M[8'hFF]=8'h33, M[8'hFE]=8'h0A, `sp`=8'hFD;
  - `stall` high for 3 cycles, then `pc_target`=8'h80.
- `int_signal` and `isCall` both high -> interrupt sequence only, no `pc_plus1` write. With `sp`=8'h00, a CALL leaves `sp`=8'hFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipelined core: memory-stage FSM states,
// writeback-select encodings and reset/vector address defaults.
package cpu_pkg;

  // Memory-stage controller states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INT_FLAGS = 3'd1,
    INT_VEC   = 3'd2,
    VEC_WAIT  = 3'd3,
    RET_WAIT  = 3'd4
  } state_t;

  // MemToReg writeback select: 2'b01 takes data memory read data.
  localparam logic [1:0] MTR_LOAD = 2'b01;

  // Default stack pointer after reset and address of the ISR entry pointer.
  localparam logic [7:0] SP_RESET_DEF     = 8'hFF;
  localparam logic [7:0] INT_VEC_ADDR_DEF = 8'h01;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register with increment/decrement strobes. Arithmetic wraps
// modulo 256; simultaneous inc and dec leave the pointer unchanged.
module stack_ptr
  import cpu_pkg::*;
#(
  parameter logic [7:0] SP_RESET = SP_RESET_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] sp
);

  // Pointer update with synchronous active-low reset.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp <= SP_RESET;
    end else if (inc && !dec) begin
      sp <= sp + 8'd1;
    end else if (dec && !inc) begin
      sp <= sp - 8'd1;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns EX/MEM control fields into data memory
// accesses, sequences CALL pushes, RET pops and interrupt entry, owns the
// stack pointer and output port, and drives stall / pc_redirect upstream.
module mem_stage_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] SP_RESET     = SP_RESET_DEF,
  parameter logic [7:0] INT_VEC_ADDR = INT_VEC_ADDR_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pc_plus1,
  input  logic [7:0] ALU_res,
  input  logic [7:0] FW_value,
  input  logic       MemWrite,
  input  logic [1:0] MemToReg,
  input  logic       IO_Write,
  input  logic [7:0] IP,
  input  logic [3:0] flags,
  input  logic       isCall,
  input  logic       isNotRet,
  input  logic       int_signal,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic       mem_re,
  input  logic [7:0] mem_rdata,
  output logic       stall,
  output logic       pc_redirect,
  output logic [7:0] pc_target,
  output logic [7:0] sp,
  output logic [7:0] io_out
);

  state_t state;
  state_t state_nxt;
  logic   sp_inc;
  logic   sp_dec;
  logic   io_we;

  stack_ptr #(
    .SP_RESET (SP_RESET)
  ) u_stack_ptr (
    .clk (clk),
    .rst (rst),
    .inc (sp_inc),
    .dec (sp_dec),
    .sp  (sp)
  );

  // An interrupt slot is a bubble, so its IO_Write is ignored.
  assign io_we = (state == IDLE) && IO_Write && !int_signal;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Output port register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_out <= 8'h00;
    end else if (io_we) begin
      io_out <= FW_value;
    end
  end

  // Decode and sequencing: next state, memory strobes, stall and redirect.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    mem_addr    = 8'h00;
    mem_wdata   = 8'h00;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 8'h00;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;

    case (state)
      IDLE: begin
        if (int_signal) begin
          mem_we    = 1'b1;
          mem_addr  = sp;
          mem_wdata = IP;
          sp_dec    = 1'b1;
          stall     = 1'b1;
          state_nxt = INT_FLAGS;
        end else if (isCall) begin
          mem_we    = 1'b1;
          mem_addr  = sp;
          mem_wdata = pc_plus1;
          sp_dec    = 1'b1;
        end else if (!isNotRet) begin
          mem_re    = 1'b1;
          mem_addr  = sp + 8'd1;
          sp_inc    = 1'b1;
          stall     = 1'b1;
          state_nxt = RET_WAIT;
        end else if (MemWrite) begin
          mem_we    = 1'b1;
          mem_addr  = ALU_res;
          mem_wdata = FW_value;
        end else if (MemToReg == MTR_LOAD) begin
          mem_re    = 1'b1;
          mem_addr  = ALU_res;
        end
      end
      INT_FLAGS: begin
        mem_we    = 1'b1;
        mem_addr  = sp;
        mem_wdata = {4'b0000, flags};
        sp_dec    = 1'b1;
        stall     = 1'b1;
        state_nxt = INT_VEC;
      end
      INT_VEC: begin
        mem_re    = 1'b1;
        mem_addr  = INT_VEC_ADDR;
        stall     = 1'b1;
        state_nxt = VEC_WAIT;
      end
      VEC_WAIT, RET_WAIT: begin
        pc_redirect = 1'b1;
        pc_target   = mem_rdata;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Reset aborts any sequence in flight: no access or redirect escapes
    // during the reset cycle.
    if (!rst) begin
      mem_addr    = 8'h00;
      mem_wdata   = 8'h00;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      stall       = 1'b0;
      pc_redirect = 1'b0;
      pc_target   = 8'h00;
      sp_inc      = 1'b0;
      sp_dec      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a randomized
// instruction stream, checked against a transaction-level model of the stack
// pointer, output port and data memory contents.
module tb_mem_stage_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] pc_plus1;
  logic [7:0] ALU_res;
  logic [7:0] FW_value;
  logic       MemWrite;
  logic [1:0] MemToReg;
  logic       IO_Write;
  logic [7:0] IP;
  logic [3:0] flags;
  logic       isCall;
  logic       isNotRet;
  logic       int_signal;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       stall;
  logic       pc_redirect;
  logic [7:0] pc_target;
  logic [7:0] sp;
  logic [7:0] io_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] m_sp;
  logic [7:0] m_io;
  logic [7:0] ref_mem [256];

  // Data memory attached to the DUT (synchronous read).
  logic [7:0] mem [256];

  mem_stage_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pc_plus1    (pc_plus1),
    .ALU_res     (ALU_res),
    .FW_value    (FW_value),
    .MemWrite    (MemWrite),
    .MemToReg    (MemToReg),
    .IO_Write    (IO_Write),
    .IP          (IP),
    .flags       (flags),
    .isCall      (isCall),
    .isNotRet    (isNotRet),
    .int_signal  (int_signal),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .sp          (sp),
    .io_out      (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic drive_idle();
    pc_plus1   = 8'h00;
    ALU_res    = 8'h00;
    FW_value   = 8'h00;
    MemWrite   = 1'b0;
    MemToReg   = 2'b00;
    IO_Write   = 1'b0;
    IP         = 8'h00;
    flags      = 4'h0;
    isCall     = 1'b0;
    isNotRet   = 1'b1;
    int_signal = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name);
    checks++;
    if (sp !== m_sp || io_out !== m_io) begin
      errors++;
      $display("FAIL %s state: sp=%h io_out=%h expected sp=%h io_out=%h", name, sp, io_out, m_sp, m_io);
    end
  endtask

  task automatic chk_mem(input string name, input logic [7:0] a);
    checks++;
    if (mem[a] !== ref_mem[a]) begin
      errors++;
      $display("FAIL %s mem[%h]=%h expected %h", name, a, mem[a], ref_mem[a]);
    end
  endtask

  task automatic do_store(input logic [7:0] a, input logic [7:0] d, input logic io);
    drive_idle();
    ALU_res = a; FW_value = d; MemWrite = 1'b1; IO_Write = io;
    MemToReg = 2'($urandom_range(0, 3));
    #2;
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== a || mem_wdata !== d || stall !== 1'b0 || pc_redirect !== 1'b0) begin
      errors++;
      $display("FAIL store: we=%b re=%b addr=%h wdata=%h stall=%b expected we=1 re=0 addr=%h wdata=%h stall=0",
               mem_we, mem_re, mem_addr, mem_wdata, stall, a, d);
    end
    ref_mem[a] = d;
    if (io) m_io = d;
    step();
    drive_idle();
    chk_state("store");
    chk_mem("store", a);
  endtask

  task automatic do_load(input logic [7:0] a, input logic io);
    drive_idle();
    ALU_res = a; MemToReg = 2'b01; FW_value = 8'($urandom); IO_Write = io;
    if (io) m_io = FW_value;
    #2;
    checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a || stall !== 1'b0) begin
      errors++;
      $display("FAIL load: re=%b we=%b addr=%h stall=%b expected re=1 we=0 addr=%h stall=0", mem_re, mem_we, mem_addr, stall, a);
    end
    step();
    drive_idle();
    checks++;
    if (mem_rdata !== ref_mem[a]) begin
      errors++;
      $display("FAIL load data: rdata=%h expected %h", mem_rdata, ref_mem[a]);
    end
    chk_state("load");
  endtask

  task automatic do_call(input logic [7:0] pc);
    logic [7:0] slot;
    drive_idle();
    isCall = 1'b1; pc_plus1 = pc;
    MemWrite = 1'($urandom); ALU_res = 8'($urandom); FW_value = 8'($urandom);
    isNotRet = 1'($urandom);
    slot = m_sp;
    #2;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== slot || mem_wdata !== pc || stall !== 1'b0 || mem_re !== 1'b0) begin
      errors++;
      $display("FAIL call: we=%b addr=%h wdata=%h stall=%b expected we=1 addr=%h wdata=%h stall=0",
               mem_we, mem_addr, mem_wdata, stall, slot, pc);
    end
    ref_mem[slot] = pc;
    m_sp = m_sp - 8'd1;
    step();
    drive_idle();
    chk_state("call");
    chk_mem("call", slot);
  endtask

  task automatic do_ret();
    logic [7:0] slot;
    drive_idle();
    isNotRet = 1'b0;
    MemWrite = 1'($urandom); ALU_res = 8'($urandom); MemToReg = 2'b01;
    slot = m_sp + 8'd1;
    #2;
    checks++;
    if (stall !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== slot || pc_redirect !== 1'b0) begin
      errors++;
      $display("FAIL ret c1: stall=%b re=%b we=%b addr=%h redir=%b expected stall=1 re=1 we=0 addr=%h redir=0",
               stall, mem_re, mem_we, mem_addr, pc_redirect, slot);
    end
    m_sp = slot;
    step();
    drive_idle();
    #1;
    checks++;
    if (pc_redirect !== 1'b1 || stall !== 1'b0 || pc_target !== ref_mem[slot] || mem_we !== 1'b0 || sp !== m_sp) begin
      errors++;
      $display("FAIL ret c2: redir=%b stall=%b target=%h we=%b sp=%h expected redir=1 stall=0 target=%h we=0 sp=%h",
               pc_redirect, stall, pc_target, mem_we, sp, ref_mem[slot], m_sp);
    end
    step();
    checks++;
    if (pc_redirect !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL ret c3: redir=%b stall=%b expected 0 0", pc_redirect, stall);
    end
    chk_state("ret");
  endtask

  // Interrupt entry; junk on the other fields (including CALL) must be ignored.
  task automatic do_int(input logic [7:0] ip_v, input logic [3:0] fl);
    logic [7:0] s0;
    logic [7:0] s1;
    drive_idle();
    int_signal = 1'b1; IP = ip_v; flags = fl;
    isCall = 1'($urandom); pc_plus1 = ~ip_v; MemWrite = 1'($urandom);
    IO_Write = 1'($urandom); FW_value = 8'($urandom); isNotRet = 1'($urandom);
    s0 = m_sp;
    s1 = m_sp - 8'd1;
    #2;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== s0 || mem_wdata !== ip_v || stall !== 1'b1 || pc_redirect !== 1'b0) begin
      errors++;
      $display("FAIL int c1: we=%b addr=%h wdata=%h stall=%b expected we=1 addr=%h wdata=%h stall=1",
               mem_we, mem_addr, mem_wdata, stall, s0, ip_v);
    end
    ref_mem[s0] = ip_v;
    step();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== s1 || mem_wdata !== {4'b0000, fl} || stall !== 1'b1 || pc_redirect !== 1'b0) begin
      errors++;
      $display("FAIL int c2: we=%b addr=%h wdata=%h stall=%b expected we=1 addr=%h wdata=%h stall=1",
               mem_we, mem_addr, mem_wdata, stall, s1, {4'b0000, fl});
    end
    ref_mem[s1] = {4'b0000, fl};
    m_sp = m_sp - 8'd2;
    step();
    checks++;
    if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h01 || stall !== 1'b1 || pc_redirect !== 1'b0) begin
      errors++;
      $display("FAIL int c3: re=%b we=%b addr=%h stall=%b expected re=1 we=0 addr=01 stall=1", mem_re, mem_we, mem_addr, stall);
    end
    step();
    drive_idle();
    #1;
    checks++;
    if (pc_redirect !== 1'b1 || stall !== 1'b0 || pc_target !== ref_mem[8'h01] || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL int c4: redir=%b stall=%b target=%h we=%b expected redir=1 stall=0 target=%h we=0",
               pc_redirect, stall, pc_target, mem_we, ref_mem[8'h01]);
    end
    step();
    checks++;
    if (pc_redirect !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL int c5: redir=%b stall=%b expected 0 0", pc_redirect, stall);
    end
    chk_state("int");
    chk_mem("int ip", s0);
    chk_mem("int flags", s1);
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    m_sp = 8'hFF;
    m_io = 8'h00;
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 ||
        stall !== 1'b0 || pc_redirect !== 1'b0 || pc_target !== 8'h00) begin
      errors++;
      $display("FAIL reset outputs: we=%b re=%b addr=%h wdata=%h stall=%b redir=%b target=%h expected all 0",
               mem_we, mem_re, mem_addr, mem_wdata, stall, pc_redirect, pc_target);
    end
    chk_state("reset");
    step();
  endtask

  task automatic test_directed();
    do_store(8'h40, 8'hA5, 1'b1);
    do_load(8'h40, 1'b0);
    do_call(8'h12);
    do_ret();
    mem[8'h01] = 8'h80;
    ref_mem[8'h01] = 8'h80;
    do_int(8'h33, 4'b1010);
  endtask

  task automatic test_reset_mid();
    int guard;
    logic [7:0] s1;
    guard = 0;
    while (m_sp != 8'h20 && guard < 300) begin
      do_ret();
      guard++;
    end
    do_store(8'h77, 8'h5C, 1'b1);
    drive_idle();
    int_signal = 1'b1; IP = 8'h44; flags = 4'hC;
    ref_mem[m_sp] = 8'h44;
    s1 = m_sp - 8'd1;
    step();
    // Now in INT_FLAGS: reset here must abort the flags push.
    rst = 1'b0;
    step();
    rst = 1'b1;
    drive_idle();
    m_sp = 8'hFF;
    m_io = 8'h00;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || stall !== 1'b0 || pc_redirect !== 1'b0) begin
      errors++;
      $display("FAIL reset mid: we=%b re=%b stall=%b redir=%b expected all 0", mem_we, mem_re, stall, pc_redirect);
    end
    chk_state("reset mid");
    step();
    checks++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || stall !== 1'b0 || pc_redirect !== 1'b0) begin
      errors++;
      $display("FAIL reset mid idle: we=%b re=%b stall=%b redir=%b expected all 0", mem_we, mem_re, stall, pc_redirect);
    end
    chk_mem("reset mid abort", s1);
    chk_mem("reset mid ip", 8'h20);
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    while (m_sp != 8'h00 && guard < 300) begin
      do_call(8'($urandom));
      guard++;
    end
    do_call(8'hC3);
    checks++;
    if (sp !== 8'hFF) begin
      errors++;
      $display("FAIL wrap down: sp=%h expected ff", sp);
    end
    do_ret();
    checks++;
    if (sp !== 8'h00) begin
      errors++;
      $display("FAIL wrap up: sp=%h expected 00", sp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: do_store(8'($urandom), 8'($urandom), 1'($urandom));
        1: do_load(8'($urandom), 1'($urandom));
        2: do_call(8'($urandom));
        3: do_ret();
        4: do_int(8'($urandom), 4'($urandom));
        default: begin
          drive_idle();
          IO_Write = 1'b1;
          FW_value = 8'($urandom);
          m_io = FW_value;
          step();
          drive_idle();
          chk_state("io");
        end
      endcase
    end
  endtask

  initial begin
    drive_idle();
    rst = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    m_sp = 8'hFF;
    m_io = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
